// File: rtl/rgbw_pkg.sv
// rgbw_pkg: constants and FSM encoding shared by the RGBW frame sender and the receive-side dispenser
package rgbw_pkg;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
  localparam int FRAME_BYTES = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, TAIL} rgbw_state_t;
endpackage

// File: rtl/rgbw_spi_byte_shifter.sv
// rgbw_spi_byte_shifter: shifts one byte MSB first as SPI mode 0 and pulses byte_done on its final cycle
module rgbw_spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       msb,
  output logic       byte_done
);
  logic [7:0] sh;
  logic [7:0] div;
  logic [2:0] bit_cnt;
  logic       half_end;
  assign half_end  = div == 8'(CLK_DIV - 1);
  assign byte_done = en & sclk & half_end & (bit_cnt == 3'd7);
  assign msb       = sh[7];
  // half-period divider; sclk toggles each half, data advances on every falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh      <= '0;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (load) begin
      sh      <= data;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (en) begin
      div <= half_end ? 8'd0 : div + 8'd1;
      if (half_end) begin
        sclk <= ~sclk;
        if (sclk) begin
          sh      <= {sh[6:0], 1'b0};
          bit_cnt <= bit_cnt == 3'd7 ? bit_cnt : bit_cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: rtl/rgbw_frame_sender.sv
// rgbw_frame_sender: sends a sync byte plus seven snapshotted payload bytes as one SPI frame
module rgbw_frame_sender
  import rgbw_pkg::*;
#(
  parameter int         CLK_DIV   = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lint_in,
  input  logic [7:0] colorIdx_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] white_in,
  input  logic [7:0] mode_in,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       busy,
  output logic       done
);
  rgbw_state_t state, state_nx;
  logic [55:0] snap;
  logic [7:0]  cnt;
  logic        half;
  logic [2:0]  byte_idx;
  logic        cnt_end;
  logic        load;
  logic [7:0]  ld_data;
  logic        msb;
  logic        byte_done;
  assign cnt_end  = cnt == 8'(CLK_DIV - 1);
  assign busy     = state != IDLE;
  assign spi_cs_n = ~busy;
  assign spi_mosi = busy & msb;
  rgbw_spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(clk), .reset(reset), .load(load), .en(state == SHIFT), .data(ld_data),
    .sclk(spi_sclk), .msb(msb), .byte_done(byte_done)
  );
  // frame sequencing: gap is two divider rounds, tail is one
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ld_data  = SYNC_BYTE;
    case (state)
      IDLE:  if (start) begin state_nx = SHIFT; load = 1'b1; end
      SHIFT: if (byte_done) state_nx = byte_idx == 3'(FRAME_BYTES - 1) ? TAIL : GAP;
      GAP:   if (cnt_end && half) begin state_nx = SHIFT; load = 1'b1; ld_data = snap[55:48]; end
      TAIL:  if (cnt_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, payload snapshot (consumed as a byte shift register) and gap/tail timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      snap     <= '0;
      cnt      <= '0;
      half     <= 1'b0;
      byte_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= state == TAIL && cnt_end;
      snap     <= state == IDLE && start ? {lint_in, colorIdx_in, red_in, green_in, blue_in, white_in, mode_in}
                : state == GAP && load ? {snap[47:0], 8'h00} : snap;
      byte_idx <= state == IDLE ? 3'd0 : state == GAP && load ? byte_idx + 3'd1 : byte_idx;
      cnt      <= (state == GAP || state == TAIL) && !cnt_end ? cnt + 8'd1 : 8'd0;
      half     <= state == GAP ? half ^ cnt_end : 1'b0;
    end
  end
endmodule
